// File: rtl/cs4344_i2s_tx_if.sv
// Sample handshake between a PCM source and the CS4344 I2S transmitter.
interface cs4344_i2s_tx_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] sample_left;
  logic [DATA_WIDTH-1:0] sample_right;
  logic                  sample_valid;
  logic                  sample_ready;

  modport master (
    output sample_left,
    output sample_right,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_left,
    input  sample_right,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/cs4344_i2s_tx.sv
// I2S transmitter for the CS4344 DAC: derives MCLK/SCLK/LRCK from one frame
// counter, double-buffers stereo pairs and serialises them MSB first with the
// usual one-SCLK delay after each LRCK edge.
module cs4344_i2s_tx #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MCLK_DIV   = 4,
  parameter int unsigned MCLK_RATIO = 512
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           enable,
  cs4344_i2s_tx_if.slave smp,
  output logic           underrun,
  output logic           MCLK,
  output logic           SCLK,
  output logic           LRCK,
  output logic           SDIN
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned FRAME = MCLK_DIV * MCLK_RATIO;
  localparam int unsigned CW    = $clog2(FRAME);
  localparam int unsigned MB    = $clog2(MCLK_DIV) - 1;
  localparam int unsigned SB    = $clog2(FRAME / 64) - 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hold_l_q, hold_l_d;
  logic [DW-1:0] hold_r_q, hold_r_d;
  logic [DW-1:0] act_l_q, act_l_d;
  logic [DW-1:0] act_r_q, act_r_d;
  logic          hold_full_q, hold_full_d;
  logic          underrun_q, underrun_d;
  logic          mclk_q, mclk_d;
  logic          sclk_q, sclk_d;
  logic          lrck_q, lrck_d;
  logic          sdin_q, sdin_d;

  logic          load_c;
  logic          accept_c;
  logic [4:0]    slot_c;
  logic [DW-1:0] word_c;
  logic [DW-1:0] word_sh_c;

  // A frame load happens on the edge that leaves cnt = 0, so the new pair is
  // in place from slot 0 onward and underrun lines up with the LRCK fall.
  assign load_c   = enable & (cnt_q == '0);
  assign accept_c = smp.sample_valid & ~hold_full_q;

  assign smp.sample_ready = ~hold_full_q;
  assign underrun         = underrun_q;
  assign MCLK             = mclk_q;
  assign SCLK             = sclk_q;
  assign LRCK             = lrck_q;
  assign SDIN             = sdin_q;

  // Frame counter and the three DAC clocks, all one register behind cnt.
  always_comb begin
    cnt_d  = '0;
    mclk_d = 1'b0;
    sclk_d = 1'b0;
    lrck_d = 1'b0;
    if (enable) begin
      cnt_d  = cnt_q + CW'(1);
      mclk_d = cnt_q[MB];
      sclk_d = cnt_q[SB];
      lrck_d = cnt_q[CW-1];
    end
  end

  // Holding register and active pair; active only changes at frame start.
  always_comb begin
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;
    underrun_d  = 1'b0;
    if (!enable) begin
      act_l_d = '0;
      act_r_d = '0;
    end else if (load_c) begin
      if (hold_full_q) begin
        act_l_d     = hold_l_q;
        act_r_d     = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        act_l_d    = '0;
        act_r_d    = '0;
        underrun_d = 1'b1;
      end
    end
    if (accept_c) begin
      hold_l_d    = smp.sample_left;
      hold_r_d    = smp.sample_right;
      hold_full_d = 1'b1;
    end
  end

  // Serial data: slot s in 1..DW carries bit DW-s of the current channel.
  always_comb begin
    slot_c    = cnt_q[CW-2:SB+1];
    word_c    = cnt_q[CW-1] ? act_r_q : act_l_q;
    word_sh_c = word_c >> (DW - 32'(slot_c));
    sdin_d    = 1'b0;
    if (enable && (slot_c != 5'd0) && (32'(slot_c) <= DW)) begin
      sdin_d = word_sh_c[0];
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q       <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      act_l_q     <= '0;
      act_r_q     <= '0;
      underrun_q  <= 1'b0;
      mclk_q      <= 1'b0;
      sclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      sdin_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
      underrun_q  <= underrun_d;
      mclk_q      <= mclk_d;
      sclk_q      <= sclk_d;
      lrck_q      <= lrck_d;
      sdin_q      <= sdin_d;
    end
  end

endmodule

// File: tb/tb_cs4344_i2s_tx.sv
// Self-checking bench for cs4344_i2s_tx with a frame-level reference model.
`timescale 1ns/1ps
module tb_cs4344_i2s_tx;

  localparam int unsigned DW    = 16;
  localparam int unsigned MDIV  = 4;
  localparam int unsigned RATIO = 512;
  localparam int unsigned F     = MDIV * RATIO;
  localparam int unsigned HALF  = F / 2;
  localparam int unsigned SCLKP = F / 64;

  logic Clk = 1'b0;
  logic Rst;
  logic enable;
  logic underrun, MCLK, SCLK, LRCK, SDIN;

  cs4344_i2s_tx_if #(.DATA_WIDTH(DW)) smp ();

  cs4344_i2s_tx #(
    .DATA_WIDTH(DW),
    .MCLK_DIV  (MDIV),
    .MCLK_RATIO(RATIO)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .enable  (enable),
    .smp     (smp),
    .underrun(underrun),
    .MCLK    (MCLK),
    .SCLK    (SCLK),
    .LRCK    (LRCK),
    .SDIN    (SDIN)
  );

  always #5 Clk = ~Clk;

  int unsigned errors;
  int unsigned checks;

  // Reference model: n counts enabled edges since the last idle period.
  int unsigned   n;
  logic          m_full;
  logic [DW-1:0] m_hold_l, m_hold_r, m_act_l, m_act_r;
  logic          m_und, m_acc;

  int unsigned und_cnt, sdin_hi, acc_cnt;
  logic [31:0] cap_l, cap_r;
  logic        sclk_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_pins();
    int unsigned   c, s;
    logic          e_mclk, e_sclk, e_lrck, e_sdin;
    logic [DW-1:0] w;
    if (n == 0) return {4'b0000, m_und, ~m_full};
    c      = (n - 1) % F;
    e_mclk = (c % MDIV) >= (MDIV / 2);
    e_sclk = (c % SCLKP) >= (SCLKP / 2);
    e_lrck = c >= HALF;
    s      = (c % HALF) / SCLKP;
    w      = e_lrck ? m_act_r : m_act_l;
    w      = w >> (DW - s);
    e_sdin = (s >= 1 && s <= DW) ? w[0] : 1'b0;
    return {e_mclk, e_sclk, e_lrck, e_sdin, m_und, ~m_full};
  endfunction

  task automatic new_pair();
    smp.sample_left  = DW'($urandom);
    smp.sample_right = DW'($urandom);
  endtask

  // One clock: advance the model on the edge, then compare all pins.
  task automatic cyc();
    logic        rdy;
    int unsigned c, s;
    @(posedge Clk);
    rdy   = ~m_full;
    m_acc = 1'b0;
    if (enable) begin
      n++;
      m_und = 1'b0;
      if ((n - 1) % F == 0) begin
        if (m_full) begin
          m_act_l = m_hold_l;
          m_act_r = m_hold_r;
          m_full  = 1'b0;
        end else begin
          m_act_l = '0;
          m_act_r = '0;
          m_und   = 1'b1;
        end
      end
    end else begin
      n       = 0;
      m_act_l = '0;
      m_act_r = '0;
      m_und   = 1'b0;
    end
    if (smp.sample_valid && rdy) begin
      m_hold_l = smp.sample_left;
      m_hold_r = smp.sample_right;
      m_full   = 1'b1;
      m_acc    = 1'b1;
    end
    #1;
    check("pins", 32'({MCLK, SCLK, LRCK, SDIN, underrun, smp.sample_ready}), 32'(exp_pins()));
    if (underrun) und_cnt++;
    if (SDIN) sdin_hi++;
    if (m_acc) acc_cnt++;
    if (SCLK && !sclk_prev && n != 0) begin
      c = (n - 1) % F;
      s = (c % HALF) / SCLKP;
      if (c >= HALF) cap_r = cap_r | (32'(SDIN) << s);
      else           cap_l = cap_l | (32'(SDIN) << s);
    end
    sclk_prev = SCLK;
  endtask

  task automatic run(input int unsigned cycles, input bit stream);
    for (int i = 0; i < int'(cycles); i++) begin
      cyc();
      if (stream && m_acc) new_pair();
    end
  endtask

  function automatic logic [31:0] slot_word(input logic [DW-1:0] w);
    logic [31:0]   r;
    logic [DW-1:0] t;
    r = '0;
    for (int s = 1; s <= int'(DW); s++) begin
      t = w >> (int'(DW) - s);
      r = r | (32'(t[0]) << s);
    end
    return r;
  endfunction

  initial begin
    errors = 0; checks = 0;
    n = 0; m_full = 1'b0; m_und = 1'b0; m_acc = 1'b0;
    m_hold_l = '0; m_hold_r = '0; m_act_l = '0; m_act_r = '0;
    und_cnt = 0; sdin_hi = 0; acc_cnt = 0; cap_l = '0; cap_r = '0; sclk_prev = 1'b0;
    Rst = 1'b1; enable = 1'b0;
    smp.sample_valid = 1'b0; smp.sample_left = '0; smp.sample_right = '0;

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("rst_pins", 32'({MCLK, SCLK, LRCK, SDIN, underrun}), 32'(0));
    check("rst_ready", 32'(smp.sample_ready), 32'(1));
    Rst = 1'b0;

    // T2: preload one pair while idle
    smp.sample_left = 16'hA55A; smp.sample_right = 16'h8001; smp.sample_valid = 1'b1;
    cyc();
    smp.sample_valid = 1'b0;
    check("t2_ready_low", 32'(smp.sample_ready), 32'(0));

    // T1/T2: first frame plays the preloaded pair
    enable = 1'b1; und_cnt = 0; cap_l = '0; cap_r = '0;
    cyc();
    check("t1_lrck_first", 32'(LRCK), 32'(0));
    run(F - 1, 1'b0);
    check("t2_left_slots", cap_l, slot_word(16'hA55A));
    check("t2_right_slots", cap_r, slot_word(16'h8001));
    check("t2_no_underrun", und_cnt, 0);

    // T3: a frame with nothing buffered; stream starts near its end
    und_cnt = 0; sdin_hi = 0;
    run(F - 100, 1'b0);
    new_pair(); smp.sample_valid = 1'b1;
    run(100, 1'b1);
    check("t3_underrun_once", und_cnt, 1);
    check("t3_sdin_mute", sdin_hi, 0);

    // T4: valid held high continuously
    und_cnt = 0; acc_cnt = 0;
    run(4 * F, 1'b1);
    check("t4_no_underrun", und_cnt, 0);
    check("t4_one_per_frame", acc_cnt, 4);

    // T5: drop enable mid right half, re-enable 10 Clk later
    run(HALF + HALF / 2, 1'b1);
    enable = 1'b0;
    run(1, 1'b1);
    check("t5_pins_off", 32'({MCLK, SCLK, LRCK, SDIN, underrun}), 32'(0));
    run(9, 1'b1);
    enable = 1'b1; und_cnt = 0;
    run(1, 1'b1);
    check("t5_restart_lrck", 32'(LRCK), 32'(0));
    check("t5_restart_underrun", 32'(underrun), 32'(0));
    run(2 * F - 1, 1'b1);
    check("t5_no_underrun", und_cnt, 0);

    // T6: asynchronous reset mid-frame
    run(700, 1'b1);
    #2;
    Rst = 1'b1;
    #1;
    check("t6_async_pins", 32'({MCLK, SCLK, LRCK, SDIN, underrun}), 32'(0));
    check("t6_async_ready", 32'(smp.sample_ready), 32'(1));
    n = 0; m_full = 1'b0; m_und = 1'b0; m_act_l = '0; m_act_r = '0; sclk_prev = 1'b0;
    enable = 1'b0; smp.sample_valid = 1'b0;
    @(posedge Clk);
    #1;
    Rst = 1'b0; enable = 1'b1; und_cnt = 0;
    cyc();
    check("t6_first_underrun", 32'(underrun), 32'(1));
    run(F + 9, 1'b0);
    check("t6_underrun_count", und_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
